// File: rtl/bcd_seg_scan.sv
// Three-digit multiplexed 7-segment driver for the packed-BCD counter bus.
// Scans ones/tens/hundreds, snapshots q per frame, blanks leading zeros and stretches cout into ovf.
module bcd_seg_scan #(
   parameter int SCAN_DIV = 50000,
   parameter int OVF_HOLD = 25000000,
   parameter bit BLANK_LZ = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   input  logic [11:0] q,
   input  logic        cout,
   output logic [2:0]  sel,
   output logic [6:0]  seg,
   output logic        dp,
   output logic        ovf
);

   localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int HW = $clog2(OVF_HOLD + 1);

   typedef enum logic [1:0] {D0, D1, D2} digit_t;

   digit_t          state, state_nxt;
   logic [CW-1:0]   scan_cnt;
   logic            tick;
   logic [11:0]     shadow;
   logic [HW-1:0]   hold_cnt;
   logic [2:0]      sel_nxt;
   logic [6:0]      seg_nxt;
   logic            dp_nxt;
   logic [3:0]      nib;
   logic            blank;

   assign tick = en && (scan_cnt == CW'(SCAN_DIV - 1));
   assign ovf  = (hold_cnt != '0);

   function automatic logic [6:0] encode(input logic [3:0] n);
      case (n)
         4'd0:    encode = 7'h40;
         4'd1:    encode = 7'h79;
         4'd2:    encode = 7'h24;
         4'd3:    encode = 7'h30;
         4'd4:    encode = 7'h19;
         4'd5:    encode = 7'h12;
         4'd6:    encode = 7'h02;
         4'd7:    encode = 7'h78;
         4'd8:    encode = 7'h00;
         4'd9:    encode = 7'h10;
         default: encode = 7'h06;
      endcase
   endfunction

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         scan_cnt <= '0;
      end else if (en) begin
         scan_cnt <= tick ? '0 : scan_cnt + 1'b1;
      end
   end

   always_comb begin
      state_nxt = state;
      if (tick) begin
         case (state)
            D0:      state_nxt = D1;
            D1:      state_nxt = D2;
            default: state_nxt = D0;
         endcase
      end
   end

   // shadow only moves on the frame boundary so a frame never mixes two q values
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state  <= D0;
         shadow <= 12'h000;
      end else begin
         state <= state_nxt;
         if (tick && state == D2) shadow <= q;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         hold_cnt <= '0;
      end else if (cout) begin
         hold_cnt <= HW'(OVF_HOLD);
      end else if (hold_cnt != '0) begin
         hold_cnt <= hold_cnt - 1'b1;
      end
   end

   // invalid nibbles (10..15) are non-zero, so they never trigger blanking
   always_comb begin
      sel_nxt = 3'b111;
      dp_nxt  = 1'b1;
      nib     = 4'h0;
      blank   = 1'b1;
      if (en) begin
         case (state)
            D0: begin
               sel_nxt = 3'b110;
               nib     = shadow[3:0];
               blank   = 1'b0;
               dp_nxt  = !ovf;
            end
            D1: begin
               sel_nxt = 3'b101;
               nib     = shadow[7:4];
               blank   = BLANK_LZ && (shadow[11:8] == 4'h0) && (shadow[7:4] == 4'h0);
            end
            D2: begin
               sel_nxt = 3'b011;
               nib     = shadow[11:8];
               blank   = BLANK_LZ && (shadow[11:8] == 4'h0);
            end
            default: begin
               sel_nxt = 3'b111;
            end
         endcase
      end
      seg_nxt = blank ? 7'h7F : encode(nib);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sel <= 3'b111;
         seg <= 7'h7F;
         dp  <= 1'b1;
      end else begin
         sel <= sel_nxt;
         seg <= seg_nxt;
         dp  <= dp_nxt;
      end
   end

endmodule

// File: tb/tb_bcd_seg_scan.sv
// Bench for bcd_seg_scan: two instances (blanking on/off) against a cycle-count based reference model.
module tb_bcd_seg_scan;

   localparam int SD = 4;
   localparam int OH = 10;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        en = 1'b0;
   logic        cout = 1'b0;
   logic [11:0] q = 12'h000;

   logic [2:0] sel_lz, sel_nz;
   logic [6:0] seg_lz, seg_nz;
   logic       dp_lz, dp_nz, ovf_lz, ovf_nz;

   bcd_seg_scan #(.SCAN_DIV(SD), .OVF_HOLD(OH), .BLANK_LZ(1'b1)) u_lz (
      .clk(clk), .rst(rst), .en(en), .q(q), .cout(cout),
      .sel(sel_lz), .seg(seg_lz), .dp(dp_lz), .ovf(ovf_lz));

   bcd_seg_scan #(.SCAN_DIV(SD), .OVF_HOLD(OH), .BLANK_LZ(1'b0)) u_nz (
      .clk(clk), .rst(rst), .en(en), .q(q), .cout(cout),
      .sel(sel_nz), .seg(seg_nz), .dp(dp_nz), .ovf(ovf_nz));

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // reference model: enabled-cycle position within a frame, frame snapshot, cycles since cout
   int          m_ecnt;
   int          m_age;
   logic [11:0] m_shadow;
   int          exp_d;

   logic [6:0] seg_tab [16];

   typedef struct packed {
      logic [11:0]     q;
      logic [2:0][6:0] lz;
      logic [2:0][6:0] nz;
   } vec_t;

   vec_t vecs [7];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_ecnt   = 0;
      m_age    = OH;
      m_shadow = 12'h000;
      exp_d    = -1;
   endtask

   function automatic logic [6:0] model_seg(input int d, input logic [11:0] sh, input bit lz);
      logic [3:0] h, t, n;
      h = sh[11:8];
      t = sh[7:4];
      n = 4'((sh >> (4 * d)) & 12'hF);
      if (lz && d == 2 && h == 0) return 7'h7F;
      if (lz && d == 1 && h == 0 && t == 0) return 7'h7F;
      return seg_tab[n];
   endfunction

   task automatic cycle();
      int d;
      logic [2:0] e_sel;
      logic [6:0] e_lz, e_nz;
      logic       e_dp, e_ovf;
      @(posedge clk);
      d = m_ecnt / SD;
      if (en) begin
         e_sel = ~(3'b001 << d);
         e_lz  = model_seg(d, m_shadow, 1'b1);
         e_nz  = model_seg(d, m_shadow, 1'b0);
         e_dp  = !(d == 0 && m_age < OH);
         exp_d = d;
         if (m_ecnt == 3 * SD - 1) begin
            m_shadow = q;
            m_ecnt   = 0;
         end else begin
            m_ecnt++;
         end
      end else begin
         e_sel = 3'b111;
         e_lz  = 7'h7F;
         e_nz  = 7'h7F;
         e_dp  = 1'b1;
         exp_d = -1;
      end
      if (cout) m_age = 0;
      else if (m_age < OH) m_age++;
      e_ovf = (m_age < OH);
      #1;
      check("cycle_lz", {20'h0, sel_lz, seg_lz, dp_lz, ovf_lz}, {20'h0, e_sel, e_lz, e_dp, e_ovf});
      check("cycle_nz", {20'h0, sel_nz, seg_nz, dp_nz, ovf_nz}, {20'h0, e_sel, e_nz, e_dp, e_ovf});
   endtask

   task automatic count_ovf(input string name);
      int n;
      n = ovf_lz ? 1 : 0;
      for (int i = 0; i < 40; i++) begin
         if (!ovf_lz) break;
         cycle();
         if (ovf_lz) n++;
      end
      check(name, 32'(n), 32'(OH));
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [2:0] walk [3];
      int guard;
      seg_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                  7'h00, 7'h10, 7'h06, 7'h06, 7'h06, 7'h06, 7'h06, 7'h06};
      // {q, lz {hund,tens,ones}, nz {hund,tens,ones}}
      vecs[0] = '{12'h305, {7'h30, 7'h40, 7'h12}, {7'h30, 7'h40, 7'h12}};
      vecs[1] = '{12'h007, {7'h7F, 7'h7F, 7'h78}, {7'h40, 7'h40, 7'h78}};
      vecs[2] = '{12'h0A0, {7'h7F, 7'h06, 7'h40}, {7'h40, 7'h06, 7'h40}};
      vecs[3] = '{12'h000, {7'h7F, 7'h7F, 7'h40}, {7'h40, 7'h40, 7'h40}};
      vecs[4] = '{12'h999, {7'h10, 7'h10, 7'h10}, {7'h10, 7'h10, 7'h10}};
      vecs[5] = '{12'hF0C, {7'h06, 7'h40, 7'h06}, {7'h06, 7'h40, 7'h06}};
      vecs[6] = '{12'h100, {7'h79, 7'h40, 7'h40}, {7'h79, 7'h40, 7'h40}};
      walk = '{3'b110, 3'b101, 3'b011};
      model_reset();

      // reset values while rst is held low
      #50;
      check("reset_lz", {20'h0, sel_lz, seg_lz, dp_lz, ovf_lz}, {20'h0, 3'b111, 7'h7F, 1'b1, 1'b0});
      check("reset_nz", {20'h0, sel_nz, seg_nz, dp_nz, ovf_nz}, {20'h0, 3'b111, 7'h7F, 1'b1, 1'b0});
      #150;
      rst = 1'b1;
      en  = 1'b1;

      // first frame: select walk with shadow = 0
      for (int k = 0; k < 12; k++) begin
         cycle();
         check("walk_sel", {29'h0, sel_lz}, {29'h0, walk[k / SD]});
         check("walk_seg", {25'h0, seg_lz}, {25'h0, (k / SD == 0) ? 7'h40 : 7'h7F});
      end

      // table of held q values, checked over a full frame after a boundary
      for (int v = 0; v < 7; v++) begin
         q = vecs[v].q;
         for (int i = 0; i < 13; i++) cycle();
         for (int i = 0; i < 12; i++) begin
            cycle();
            if (exp_d >= 0) begin
               check("tab_lz", {25'h0, seg_lz}, {25'h0, vecs[v].lz[exp_d]});
               check("tab_nz", {25'h0, seg_nz}, {25'h0, vecs[v].nz[exp_d]});
            end
         end
      end

      // q changes mid-frame: no tearing until the next D0
      q = 12'h123;
      for (int i = 0; i < 25; i++) cycle();
      guard = 0;
      while (m_ecnt != SD + 1 && guard < 30) begin
         cycle();
         guard++;
      end
      check("tear_align", 32'(m_ecnt), 32'(SD + 1));
      q = 12'h456;
      for (int i = 0; i < 2 * SD - 1; i++) begin
         cycle();
         if (exp_d == 1) check("tear_tens", {25'h0, seg_lz}, {25'h0, 7'h24});
         if (exp_d == 2) check("tear_hund", {25'h0, seg_lz}, {25'h0, 7'h79});
      end
      cycle();
      check("tear_ones_new", {25'h0, seg_lz}, {25'h0, 7'h02});
      for (int i = 0; i < 11; i++) cycle();

      // ovf stretch and retrigger
      cout = 1'b1;
      cycle();
      cout = 1'b0;
      count_ovf("ovf_len");
      for (int i = 0; i < 3; i++) cycle();
      cout = 1'b1;
      cycle();
      cout = 1'b0;
      for (int i = 0; i < OH - 3; i++) cycle();
      cout = 1'b1;
      cycle();
      cout = 1'b0;
      count_ovf("ovf_retrig");

      // en dropped at D1 count 2 for 5 clocks
      guard = 0;
      while (m_ecnt != SD + 2 && guard < 30) begin
         cycle();
         guard++;
      end
      check("en_align", 32'(m_ecnt), 32'(SD + 2));
      en = 1'b0;
      cycle();
      check("en_off", {20'h0, sel_lz, seg_lz, dp_lz, 1'b0}, {20'h0, 3'b111, 7'h7F, 1'b1, 1'b0});
      for (int i = 0; i < 4; i++) cycle();
      en = 1'b1;
      cycle();
      check("en_resume", {29'h0, sel_lz}, {29'h0, 3'b101});
      for (int i = 0; i < 8; i++) cycle();

      // asynchronous reset mid-frame while ovf is held
      cout = 1'b1;
      cycle();
      cout = 1'b0;
      cycle();
      #2;
      rst = 1'b0;
      #1;
      check("async_rst_lz", {20'h0, sel_lz, seg_lz, dp_lz, ovf_lz}, {20'h0, 3'b111, 7'h7F, 1'b1, 1'b0});
      check("async_rst_nz", {20'h0, sel_nz, seg_nz, dp_nz, ovf_nz}, {20'h0, 3'b111, 7'h7F, 1'b1, 1'b0});
      model_reset();
      @(negedge clk);
      rst = 1'b1;
      for (int i = 0; i < 12; i++) cycle();

      // randomized traffic against the model
      for (int i = 0; i < 400; i++) begin
         en   = ($urandom_range(0, 9) != 0);
         cout = ($urandom_range(0, 24) == 0);
         if ($urandom_range(0, 7) == 0) begin
            if ($urandom_range(0, 3) == 0) q = 12'($urandom);
            else q = {4'($urandom_range(0, 9) * ($urandom_range(0, 1))),
                      4'($urandom_range(0, 9) * ($urandom_range(0, 1))),
                      4'($urandom_range(0, 9))};
         end
         cycle();
      end
      cout = 1'b0;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
